// File: rtl/keypad_pkg.sv
// Shared definitions for the calculator keypad front end: scan states,
// key codes, matrix dimensions and row/index helper functions.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 5;

   localparam logic [4:0] KEY_0 = 5'h00, KEY_1 = 5'h01, KEY_2 = 5'h02, KEY_3 = 5'h03,
                          KEY_4 = 5'h04, KEY_5 = 5'h05, KEY_6 = 5'h06, KEY_7 = 5'h07,
                          KEY_8 = 5'h08, KEY_9 = 5'h09, KEY_AC = 5'h0A, KEY_CE = 5'h0B,
                          KEY_NEG = 5'h0C, KEY_DIV = 5'h0D, KEY_MUL = 5'h0E,
                          KEY_SUB = 5'h0F, KEY_ADD = 5'h10, KEY_EQ = 5'h11;

   // True when exactly one row line is pulled low.
   function automatic logic oneLow(input logic [3:0] rows);
      int n;
      n = 0;
      for (int i = 0; i < NUM_ROWS; i++)
         if (!rows[i]) n++;
      return (n == 1);
   endfunction

   function automatic logic [1:0] lowRow(input logic [3:0] rows);
      logic [1:0] r;
      r = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--)
         if (!rows[i]) r = 2'(i);
      return r;
   endfunction

   function automatic logic [4:0] keyIndex(input logic [1:0] row, input logic [2:0] col);
      return 5'(row) * 5'(NUM_COLS) + 5'(col);
   endfunction

   function automatic logic isMapped(input logic [4:0] idx);
      return (idx < 5'd18);
   endfunction

   function automatic logic [4:0] idxToCode(input logic [4:0] idx);
      case (idx)
         5'd0:  return KEY_0;   5'd1:  return KEY_1;   5'd2:  return KEY_2;
         5'd3:  return KEY_3;   5'd4:  return KEY_4;   5'd5:  return KEY_5;
         5'd6:  return KEY_6;   5'd7:  return KEY_7;   5'd8:  return KEY_8;
         5'd9:  return KEY_9;   5'd10: return KEY_AC;  5'd11: return KEY_CE;
         5'd12: return KEY_NEG; 5'd13: return KEY_DIV; 5'd14: return KEY_MUL;
         5'd15: return KEY_SUB; 5'd16: return KEY_ADD; 5'd17: return KEY_EQ;
         default: return KEY_0;
      endcase
   endfunction

endpackage

// File: rtl/keypad_colscan.sv
// Column dwell timer and active-low column drive; the tick marks the last
// cycle of each dwell, when the synchronized rows are sampled.
module keypad_colscan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_freeze,
   input  logic       i_advance,
   output logic       o_tick,
   output logic [2:0] o_col,
   output logic [4:0] o_colOut
);

   localparam int TW = $clog2(SCAN_DIV);

   logic [TW-1:0] r_timer;
   logic [2:0]    r_col;
   logic          w_step;

   assign o_tick   = (r_timer == TW'(SCAN_DIV - 1));
   assign w_step   = o_tick && (i_advance || !i_freeze);
   assign o_col    = r_col;
   assign o_colOut = ~(5'b00001 << r_col);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_timer <= '0;
         r_col   <= 3'd0;
      end else begin
         r_timer <= o_tick ? '0 : r_timer + 1'b1;
         if (w_step)
            r_col <= (r_col == 3'(NUM_COLS - 1)) ? 3'd0 : r_col + 3'd1;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 keypad scanner with press/release debounce and a one-cycle valid strobe.
// Optional auto-repeat for digit keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
`ifdef KEYPAD_AUTOREPEAT_EN
   ,parameter int REPEAT_CNT  = 64
`endif
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [4:0] col_out,
   output logic [4:0] key_input,
   output logic       valid
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   logic [3:0]    r_sync1, r_sync2;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_pattern;
   logic [4:0]    r_key;
   logic          r_valid;

   logic          w_tick, w_freeze, w_advance;
   logic          w_oneLow, w_match, w_allHigh, w_cntFull;
   logic          w_pressDone, w_relDone;
   logic [2:0]    w_col;
   logic [4:0]    w_colOut, w_idx;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT + 1);
   logic [RW-1:0] r_rep;
   logic          r_digit;
`endif

   keypad_colscan #(.SCAN_DIV(SCAN_DIV)) u_colscan (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_freeze  (w_freeze),
      .i_advance (w_advance),
      .o_tick    (w_tick),
      .o_col     (w_col),
      .o_colOut  (w_colOut)
   );

   assign w_oneLow  = oneLow(r_sync2);
   assign w_match   = (r_sync2 == r_pattern);
   assign w_allHigh = (r_sync2 == 4'hF);
   assign w_cntFull = (int'(r_cnt) + 1) >= DEBOUNCE_CNT;
   assign w_idx     = keyIndex(lowRow(r_sync2), w_col);

   // With a debounce count of one, the first qualifying tick completes the phase.
   assign w_pressDone = w_tick && ((r_state == SCAN && w_oneLow && DEBOUNCE_CNT <= 1) ||
                                   (r_state == PRESS_DB && w_match && w_cntFull));
   assign w_relDone   = w_tick && w_allHigh && ((r_state == HELD && DEBOUNCE_CNT <= 1) ||
                                                (r_state == REL_DB && w_cntFull));
   assign w_advance   = w_relDone || (w_tick && r_state == PRESS_DB && !w_match);
   assign w_freeze    = (r_state != SCAN) || w_oneLow;

   assign col_out   = w_colOut;
   assign key_input = r_key;
   assign valid     = r_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= row_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SCAN;
         r_cnt     <= '0;
         r_pattern <= 4'hF;
         r_key     <= KEY_0;
         r_valid   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep     <= '0;
         r_digit   <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               SCAN: begin
                  if (w_oneLow) begin
                     r_pattern <= r_sync2;
                     r_cnt     <= CW'(1);
                     r_state   <= PRESS_DB;
                  end
               end
               PRESS_DB: begin
                  if (w_match) begin
                     if (!w_cntFull) r_cnt <= r_cnt + 1'b1;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= SCAN;
                  end
               end
               HELD: begin
                  if (w_allHigh) begin
                     r_cnt   <= CW'(1);
                     r_state <= REL_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
                     r_rep   <= '0;
                  end else if (r_digit) begin
                     if ((int'(r_rep) + 1) >= REPEAT_CNT) begin
                        r_valid <= 1'b1;
                        r_rep   <= '0;
                     end else begin
                        r_rep   <= r_rep + 1'b1;
                     end
`endif
                  end
               end
               REL_DB: begin
                  if (w_allHigh) begin
                     if (!w_cntFull) r_cnt <= r_cnt + 1'b1;
                  end else begin
                     r_state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                     r_rep   <= '0;
`endif
                  end
               end
               default: r_state <= SCAN;
            endcase
         end

         // Completion overrides the per-state bookkeeping above.
         if (w_pressDone) begin
            r_state <= HELD;
            if (isMapped(w_idx)) begin
               r_key   <= idxToCode(w_idx);
               r_valid <= 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep   <= '0;
            r_digit <= isMapped(w_idx) && (w_idx <= 5'd9);
`endif
         end
         if (w_relDone) begin
            r_state <= SCAN;
            r_cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a row model driven by col_out,
// a vector table, and a scoreboard queue of expected key codes.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REPEAT_CNT   = 5;
`endif

   typedef struct {
      int         idx;
      int         ghost;
      int         holdAfter;
      bit         expValid;
      logic [4:0] code;
      bit         checkHeld;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [4:0] col_out, key_input;
   logic       valid;

   logic [19:0] keys = '0;
   logic [4:0]  expQ[$];
   int          validTimes[$];
   int          compared = 0, mismatched = 0, validCount = 0, cyc = 0;
   bit          sawHeld = 1'b0, sawRel = 1'b0;
   logic [4:0]  lastCode = 5'h00;
   vec_t        vecs[8];

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEYPAD_AUTOREPEAT_EN
      ,.REPEAT_CNT  (REPEAT_CNT)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_input (key_input),
      .valid     (valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Physical keypad: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++)
            if (keys[r*5 + c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (dut.r_state == HELD)   sawHeld = 1'b1;
      if (dut.r_state == REL_DB) sawRel  = 1'b1;
      if (valid === 1'b1) begin
         logic [4:0] e;
         validCount++;
         validTimes.push_back(cyc);
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_valid: key_input=%0h, no strobe expected", key_input);
         end else begin
            e = expQ.pop_front();
            if (key_input !== e) begin
               mismatched++;
               $display("[TB] FAIL key_code: got %0h, expected %0h", key_input, e);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drainCheck(input string name);
      checkOutput(name, expQ.size(), 0);
      expQ.delete();
   endtask

   task automatic waitValid(input string name, input int start, input int limit);
      int n;
      n = 0;
      while (validCount == start && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (validCount == start) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s_timeout: no valid within %0d cycles, expected one", name, limit);
      end
   endtask

   task automatic resetDut();
      keys = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lastCode = 5'h00;
   endtask

   task automatic applyStimulus(input vec_t v);
      int    start;
      string nm;
      nm = $sformatf("key%0d", v.idx);
      keys = '0;
      keys[5'(v.idx)] = 1'b1;
      if (v.ghost >= 0) keys[5'(v.ghost)] = 1'b1;
      start   = validCount;
      sawHeld = 1'b0;
      sawRel  = 1'b0;
      if (v.expValid) begin
         expQ.push_back(v.code);
         lastCode = v.code;
         waitValid(nm, start, 60);
         repeat (v.holdAfter) @(negedge clk);
      end else begin
         repeat (60) @(negedge clk);
      end
      keys = '0;
      repeat (40) @(negedge clk);
      checkOutput({nm, "_valids"}, validCount - start, v.expValid ? 1 : 0);
      drainCheck({nm, "_pending"});
      checkOutput({nm, "_state"}, dut.r_state, SCAN);
      checkOutput({nm, "_keyhold"}, key_input, lastCode);
      if (v.checkHeld) begin
         checkOutput({nm, "_sawHeld"}, sawHeld, 1);
         checkOutput({nm, "_sawRelDb"}, sawRel, 1);
      end
   endtask

`ifdef KEYPAD_AUTOREPEAT_EN
   task automatic repeatTest(input int idx, input logic [4:0] code, input int expCount);
      int start, t0;
      string nm;
      nm = $sformatf("repeat%0d", idx);
      keys = '0;
      keys[5'(idx)] = 1'b1;
      start = validCount;
      t0    = validTimes.size();
      for (int k = 0; k < expCount; k++) expQ.push_back(code);
      waitValid(nm, start, 60);
      repeat (70) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      checkOutput({nm, "_count"}, validCount - start, expCount);
      for (int k = 1; k < expCount && t0 + k < validTimes.size(); k++)
         checkOutput($sformatf("%s_gap%0d", nm, k), validTimes[t0+k] - validTimes[t0+k-1], 20);
      drainCheck({nm, "_pending"});
      checkOutput({nm, "_key"}, key_input, code);
   endtask
`endif

   initial begin
      int t0, start;

      vecs[0] = '{13, -1, 40, 1'b1, 5'h0D, 1'b0};
      vecs[1] = '{0,  -1, 8,  1'b1, 5'h00, 1'b0};
      vecs[2] = '{4,  -1, 8,  1'b1, 5'h04, 1'b0};
      vecs[3] = '{10, -1, 8,  1'b1, 5'h0A, 1'b0};
      vecs[4] = '{17, -1, 8,  1'b1, 5'h11, 1'b0};
      vecs[5] = '{19, -1, 0,  1'b0, 5'h00, 1'b1};
      vecs[6] = '{18, -1, 0,  1'b0, 5'h00, 1'b1};
      vecs[7] = '{0,   5, 0,  1'b0, 5'h00, 1'b0};

      // Reset values, then column rotation every dwell.
      repeat (2) @(negedge clk);
      checkOutput("rst_col_out", col_out, 5'b11110);
      checkOutput("rst_key_input", key_input, 5'h00);
      checkOutput("rst_valid", valid, 1'b0);
      checkOutput("rst_state", dut.r_state, SCAN);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         logic [4:0] e;
         e = ~(5'b00001 << (k % 5));
         checkOutput($sformatf("rotate%0d", k), col_out, e);
         repeat (4) @(negedge clk);
      end

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Bounce: two matching ticks then a drop, re-press lands on col 1 at dwell 8.
      resetDut();
      t0    = cyc;
      start = validCount;
      repeat (4) @(negedge clk);
      keys[1] = 1'b1;
      repeat (8) @(negedge clk);
      keys[1] = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("bounce_quiet", validCount - start, 0);
      expQ.push_back(5'h01);
      lastCode = 5'h01;
      keys[1] = 1'b1;
      waitValid("bounce", start, 60);
      if (validTimes.size() > 0)
         checkOutput("bounce_latency", validTimes[$] - t0, 44);
      repeat (8) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      checkOutput("bounce_count", validCount - start, 1);
      drainCheck("bounce_pending");

      // Reset while the press is partially debounced.
      resetDut();
      start = validCount;
      repeat (8) @(negedge clk);
      keys[12] = 1'b1;
      repeat (9) @(negedge clk);
      checkOutput("middb_state", dut.r_state, PRESS_DB);
      checkOutput("middb_cnt", 32'(dut.r_cnt), 2);
      rst  = 1'b1;
      keys = '0;
      @(negedge clk);
      checkOutput("middb_valid", valid, 1'b0);
      checkOutput("middb_rst_state", dut.r_state, SCAN);
      checkOutput("middb_col_out", col_out, 5'b11110);
      checkOutput("middb_rst_cnt", 32'(dut.r_cnt), 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("middb_no_valid", validCount - start, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
      repeatTest(7, 5'h07, 4);
      repeatTest(16, 5'h10, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
